spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Converts a single-bit spike train, such as the spike output of a leaky-integrate-and-fire neuron, back into multi-bit values. It observes the train over consecutive programmable windows. For each window it reports the spike count (rate code) and the index of the first spike (time-to-first-spike code). Results leave through a valid/ready output register, so a host or downstream logic can read decoded activity.

Parameters:
CW, 8, width of window_len, rate, ttfs and all internal counters.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-low
enable  input  1  1 = decode windows continuously; 0 = idle/abort
spike  input  1  spike train, sampled once per clk while counting
window_len  input  CW  window length in cycles; 0 means 2^CW
rate  output  CW  spike count of last completed window
ttfs  output  CW  cycle index (0-based) of first spike in last completed window
ttfs_hit  output  1  1 = at least one spike in last completed window
rate_valid  output  1  result register holds an unconsumed result
rate_ready  input  1  consumer accepts result when rate_valid & rate_ready
overrun  output  1  sticky: an unconsumed result was overwritten

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - rate, ttfs, ttfs_hit, rate_valid, overrun, and all counters/latches become 0.
  - Reset wins over every other event, including mid-window; the partial window is discarded.
- FSM states: IDLE, COUNT.
  - IDLE→COUNT on an edge with enable=1. At that edge, L = (window_len==0 ? 2^CW : window_len) is latched, and wcnt, scnt and first_seen are cleared.
  - COUNT→IDLE on any edge with enable=0. The window is aborted: counters cleared, no result produced, output register untouched.
- spike is not sampled in IDLE.
- Counting, per cycle in COUNT:
  - If spike=1: scnt increments, saturating at 2^CW-1.
  - If spike=1 and first_seen=0: ttfs latch takes wcnt and first_seen is set.
  - wcnt increments each cycle.
- Window end (COUNT cycle with wcnt==L-1):
  - That cycle's spike is included in the result.
  - On the edge, the output register loads:
    - rate = final saturated count
    - ttfs = first-spike index, or 0 if none
    - ttfs_hit = first_seen, including a spike on this cycle
  - rate_valid is set to 1.
  - In the same edge, if enable=1, the next window starts with no gap: L is re-latched from the current window_len, counters are cleared, and the state stays COUNT.
  - window_len changes mid-window take effect only at the next window start.
- Latency: rate_valid rises on the edge ending the window's last cycle. It is visible in the first cycle after the window.
- Handshake:
  - Transfer occurs on an edge with rate_valid=1 and rate_ready=1; rate_valid clears unless a new result loads on the same edge.
  - Result data is stable while rate_valid=1 and no new result loads.
  - rate_ready is ignored while rate_valid=0.
- Simultaneous events at a window-end edge:
  - rate_valid=1 and rate_ready=1: the old result transfers, the new result loads, rate_valid stays 1, overrun is unchanged.
  - rate_valid=1 and rate_ready=0: the new result overwrites and overrun is set to 1.
- overrun is cleared only by reset.
- Arithmetic: all counters are unsigned CW bits. wcnt counts 0..L-1 and never wraps within a window, including when L=2^CW (wcnt reaches 2^CW-1).
- Window length 1: every COUNT cycle produces a result, with rate equal to spike and ttfs=0.

Test Plan:
- Basic window: CW=8, window_len=10, enable held, spike=1 on window cycles 2, 5, 9, rate_ready=1 → one cycle after cycle 9:
  - rate_valid=1, rate=3, ttfs=2, ttfs_hit=1.
  - Next window reports rate=0, ttfs_hit=0, ttfs=0.
- Saturation/max window: window_len=0 (L=256), spike held 1 → rate=255, ttfs=0, ttfs_hit=1, result exactly 256 cycles after COUNT entry.
- Overrun and simultaneity:
  - window_len=4, rate_ready=0, spikes 1 then 2 per window → after the second window, rate=2 and overrun=1.
  - Then rate_ready=1 held → each subsequent window end keeps rate_valid=1 with no new overrun.
  - Drop ready for one window → rate_valid clears one cycle after the accept.
- Abort: window_len=20, 5 spikes, enable=0 at window cycle 12 → no result, rate_valid unchanged. Re-enable → fresh window, count starts from 0.
- Mid-window length change: window_len 8→3 during cycle 4 → current window still ends after 8 cycles; next window is 3 cycles.
- Reset mid-window: rst_n=0 for one edge at window cycle 6 with rate_valid=1 and overrun=1 → all outputs 0, state IDLE; decoding resumes from a fresh window once rst_n=1 and enable=1.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Decodes a 1-bit spike train over back-to-back programmable windows into a
// spike count and first-spike index, delivered through a valid/ready register.
module spike_rate_decoder #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          spike,
    input  logic [CW-1:0] window_len,
    output logic [CW-1:0] rate,
    output logic [CW-1:0] ttfs,
    output logic          ttfs_hit,
    output logic          rate_valid,
    input  logic          rate_ready,
    output logic          overrun
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state_reg, state_next;
    logic [CW-1:0] last_reg, last_next;
    logic [CW-1:0] wcnt_reg, wcnt_next;
    logic [CW-1:0] scnt_reg, scnt_next;
    logic [CW-1:0] ttfs_lat_reg, ttfs_lat_next;
    logic          first_seen_reg, first_seen_next;
    logic [CW-1:0] rate_reg, rate_next;
    logic [CW-1:0] ttfs_reg, ttfs_next;
    logic          hit_reg, hit_next;
    logic          valid_reg, valid_next;
    logic          overrun_reg, overrun_next;

    logic [CW-1:0] scnt_fin;
    logic [CW-1:0] ttfs_fin;
    logic          first_fin;
    logic          win_end;

    always_comb begin
        // Values including the current cycle's spike; used both to advance the
        // window and to load the result on its final cycle.
        scnt_fin  = (spike && (scnt_reg != '1)) ? scnt_reg + ONE : scnt_reg;
        first_fin = first_seen_reg | spike;
        ttfs_fin  = first_seen_reg ? ttfs_lat_reg : (spike ? wcnt_reg : '0);
        win_end   = (state_reg == COUNT) && enable && (wcnt_reg == last_reg);
    end

    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        wcnt_next       = wcnt_reg;
        scnt_next       = scnt_reg;
        ttfs_lat_next   = ttfs_lat_reg;
        first_seen_next = first_seen_reg;
        rate_next       = rate_reg;
        ttfs_next       = ttfs_reg;
        hit_next        = hit_reg;
        valid_next      = valid_reg;
        overrun_next    = overrun_reg;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next      = COUNT;
                    // Store L-1: window_len==0 wraps to 2^CW-1, i.e. L=2^CW.
                    last_next       = window_len - ONE;
                    wcnt_next       = '0;
                    scnt_next       = '0;
                    ttfs_lat_next   = '0;
                    first_seen_next = 1'b0;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_next      = IDLE;
                    wcnt_next       = '0;
                    scnt_next       = '0;
                    ttfs_lat_next   = '0;
                    first_seen_next = 1'b0;
                end else if (win_end) begin
                    last_next       = window_len - ONE;
                    wcnt_next       = '0;
                    scnt_next       = '0;
                    ttfs_lat_next   = '0;
                    first_seen_next = 1'b0;
                end else begin
                    wcnt_next       = wcnt_reg + ONE;
                    scnt_next       = scnt_fin;
                    ttfs_lat_next   = ttfs_fin;
                    first_seen_next = first_fin;
                end
            end
            default: state_next = IDLE;
        endcase

        if (win_end) begin
            rate_next  = scnt_fin;
            ttfs_next  = ttfs_fin;
            hit_next   = first_fin;
            valid_next = 1'b1;
            if (valid_reg && !rate_ready)
                overrun_next = 1'b1;
        end else if (valid_reg && rate_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_reg       <= '0;
            wcnt_reg       <= '0;
            scnt_reg       <= '0;
            ttfs_lat_reg   <= '0;
            first_seen_reg <= 1'b0;
            rate_reg       <= '0;
            ttfs_reg       <= '0;
            hit_reg        <= 1'b0;
            valid_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            wcnt_reg       <= wcnt_next;
            scnt_reg       <= scnt_next;
            ttfs_lat_reg   <= ttfs_lat_next;
            first_seen_reg <= first_seen_next;
            rate_reg       <= rate_next;
            ttfs_reg       <= ttfs_next;
            hit_reg        <= hit_next;
            valid_reg      <= valid_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign rate       = rate_reg;
    assign ttfs       = ttfs_reg;
    assign ttfs_hit   = hit_reg;
    assign rate_valid = valid_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: stimulus pushes expected results,
// a negedge monitor pops and compares each accepted result.
module tb_spike_rate_decoder;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          spike;
    logic [CW-1:0] window_len;
    logic [CW-1:0] rate;
    logic [CW-1:0] ttfs;
    logic          ttfs_hit;
    logic          rate_valid;
    logic          rate_ready;
    logic          overrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] exp_q[$];   // {hit, ttfs, rate}

    spike_rate_decoder #(.CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .spike     (spike),
        .window_len(window_len),
        .rate      (rate),
        .ttfs      (ttfs),
        .ttfs_hit  (ttfs_hit),
        .rate_valid(rate_valid),
        .rate_ready(rate_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [255:0] m);
        for (int k = 0; k < n; k++) begin
            spike = m[k];
            tick();
        end
        spike = 1'b0;
    endtask

    task automatic push(input int r, input int t, input int h);
        exp_q.push_back({h[0], t[7:0], r[7:0]});
    endtask

    // Monitor: a result transfers on the coming edge when valid & ready.
    always @(negedge clk) begin
        if (rst_n && rate_valid && rate_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("rate", int'(rate), int'(e[7:0]));
                chk("ttfs", int'(ttfs), int'(e[15:8]));
                chk("ttfs_hit", int'(ttfs_hit), int'(e[16]));
                $display("result rate=%0d ttfs=%0d hit=%0d", rate, ttfs, ttfs_hit);
            end
        end
    end

    initial begin
        logic [255:0] ones;
        ones = '1;
        rst_n = 1'b0; enable = 1'b0; spike = 1'b0; rate_ready = 1'b0; window_len = '0;
        tick(); tick(); tick();
        chk("reset_rate", int'(rate), 0);
        chk("reset_ttfs", int'(ttfs), 0);
        chk("reset_hit", int'(ttfs_hit), 0);
        chk("reset_valid", int'(rate_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // Basic window: spikes at 2, 5, 9 of a 10-cycle window, then an empty one.
        window_len = 8'd10; rate_ready = 1'b1; enable = 1'b1;
        tick();
        push(3, 2, 1);
        run(10, 256'h224);
        chk("basic_valid", int'(rate_valid), 1);
        push(0, 0, 0);
        run(10, '0);
        enable = 1'b0;
        tick();
        chk("basic_valid_clear", int'(rate_valid), 0);

        // Maximum window (window_len=0 -> 256) with saturating count.
        window_len = 8'd0; enable = 1'b1;
        tick();
        push(255, 0, 1);
        run(255, ones);
        chk("max_not_early", int'(rate_valid), 0);
        run(1, ones);
        chk("max_valid_at_256", int'(rate_valid), 1);
        enable = 1'b0;
        tick();

        // Length-1 windows with ready held: back-to-back accept and load.
        window_len = 8'd1; enable = 1'b1;
        tick();
        push(1, 0, 1); run(1, 256'h1);
        push(0, 0, 0); run(1, 256'h0);
        push(1, 0, 1); run(1, 256'h1);
        chk("simul_valid_held", int'(rate_valid), 1);
        chk("simul_no_overrun", int'(overrun), 0);
        enable = 1'b0;
        tick();
        chk("simul_valid_clear", int'(rate_valid), 0);

        // Overrun: two 4-cycle windows with no consumer.
        window_len = 8'd4; rate_ready = 1'b0; enable = 1'b1;
        tick();
        run(4, 256'h2);
        chk("no_overrun_first", int'(overrun), 0);
        run(4, 256'h9);
        chk("overrun_rate", int'(rate), 2);
        chk("overrun_set", int'(overrun), 1);
        chk("overrun_valid", int'(rate_valid), 1);
        push(2, 0, 1);
        enable = 1'b0; rate_ready = 1'b1;
        tick();
        chk("overrun_accept_clear", int'(rate_valid), 0);
        chk("overrun_sticky", int'(overrun), 1);

        // Abort at window cycle 12 of 20, then a fresh window.
        window_len = 8'd20; enable = 1'b1;
        tick();
        run(12, 256'h1f);
        enable = 1'b0;
        tick();
        tick();
        chk("abort_no_result", int'(rate_valid), 0);
        enable = 1'b1;
        tick();
        push(1, 7, 1);
        run(19, 256'h80);
        chk("fresh_not_early", int'(rate_valid), 0);
        run(1, '0);
        chk("fresh_valid", int'(rate_valid), 1);
        enable = 1'b0;
        tick();

        // window_len change mid-window takes effect on the next window.
        window_len = 8'd8; enable = 1'b1;
        tick();
        push(1, 6, 1);
        run(4, '0);
        window_len = 8'd3;
        run(3, 256'h4);
        chk("len8_not_early", int'(rate_valid), 0);
        run(1, '0);
        chk("len8_valid", int'(rate_valid), 1);
        push(1, 2, 1);
        run(2, '0);
        chk("len3_not_early", int'(rate_valid), 0);
        run(1, 256'h1);
        chk("len3_valid", int'(rate_valid), 1);
        enable = 1'b0;
        tick();

        // Reset mid-window with an unconsumed result and overrun set.
        window_len = 8'd2; rate_ready = 1'b0; enable = 1'b1;
        tick();
        run(2, 256'h1);
        window_len = 8'd10;
        run(2, '0);
        chk("pre_reset_overrun", int'(overrun), 1);
        chk("pre_reset_valid", int'(rate_valid), 1);
        run(6, '0);
        rst_n = 1'b0;
        tick();
        chk("rst_rate", int'(rate), 0);
        chk("rst_hit", int'(ttfs_hit), 0);
        chk("rst_valid", int'(rate_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1; rate_ready = 1'b1;
        tick();
        push(1, 3, 1);
        run(10, 256'h8);
        chk("post_reset_valid", int'(rate_valid), 1);
        enable = 1'b0;
        tick();
        tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
